// File: rtl/hsv_to_rgb.sv
// hsv_to_rgb: fixed 3-stage HSV to RGB converter with raw passthrough.
// Optional macro HSV_TO_RGB_GRAY_EXACT_EN forces (V,V,V) when S==0.
module hsv_to_rgb #(
    parameter int SB_W = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_in,
    input  logic [SB_W-1:0] sb_in,
    input  logic            convert_en,
    input  logic [23:0]     hsv_in,
    output logic            valid_out,
    output logic [SB_W-1:0] sb_out,
    output logic [23:0]     rgb_out
);

    // ---------------- stage 1 ----------------
    logic [10:0]     h6;
    logic            s1_valid;
    logic [SB_W-1:0] s1_sb;
    logic            s1_conv;
    logic [2:0]      s1_sector;
    logic [7:0]      s1_f;
    logic [7:0]      s1_s;
    logic [7:0]      s1_v;
    logic [23:0]     s1_raw;
`ifdef HSV_TO_RGB_GRAY_EXACT_EN
    logic            s1_gray;
`endif

    // H*6 fits in 11 bits: 255*6 = 1530 -> sector 5, f = 250
    assign h6 = {3'b000, hsv_in[23:16]} * 11'd6;

    // stage 1 control: valid, sideband and mode cleared by reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_sb    <= '0;
            s1_conv  <= 1'b0;
        end else begin
            s1_valid <= valid_in;
            s1_sb    <= sb_in;
            s1_conv  <= convert_en;
        end
    end

    // stage 1 data: sector/fraction split, S and V captured
    always_ff @(posedge clk) begin
        s1_sector <= h6[10:8];
        s1_f      <= h6[7:0];
        s1_s      <= hsv_in[15:8];
        s1_v      <= hsv_in[7:0];
        s1_raw    <= hsv_in;
`ifdef HSV_TO_RGB_GRAY_EXACT_EN
        s1_gray   <= (hsv_in[15:8] == 8'd0);
`endif
    end

    // ---------------- stage 2 ----------------
    logic [15:0]     sf_prod;
    logic [15:0]     sfn_prod;
    logic            s2_valid;
    logic [SB_W-1:0] s2_sb;
    logic            s2_conv;
    logic [2:0]      s2_sector;
    logic [7:0]      s2_sf;
    logic [7:0]      s2_sfn;
    logic [7:0]      s2_si;
    logic [7:0]      s2_v;
    logic [23:0]     s2_raw;
`ifdef HSV_TO_RGB_GRAY_EXACT_EN
    logic            s2_gray;
`endif

    assign sf_prod  = {8'd0, s1_s} * {8'd0, s1_f};
    assign sfn_prod = {8'd0, s1_s} * {8'd0, 8'd255 - s1_f};

    // stage 2 control: advances every cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_sb    <= '0;
            s2_conv  <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            s2_sb    <= s1_sb;
            s2_conv  <= s1_conv;
        end
    end

    // stage 2 data: saturation products, truncated to 8 bits
    always_ff @(posedge clk) begin
        s2_sector <= s1_sector;
        s2_sf     <= sf_prod[15:8];
        s2_sfn    <= sfn_prod[15:8];
        s2_si     <= 8'd255 - s1_s;
        s2_v      <= s1_v;
        s2_raw    <= s1_raw;
`ifdef HSV_TO_RGB_GRAY_EXACT_EN
        s2_gray   <= s1_gray;
`endif
    end

    // ---------------- stage 3 ----------------
    logic [15:0] p_prod;
    logic [15:0] q_prod;
    logic [15:0] t_prod;
    logic [7:0]  p;
    logic [7:0]  q;
    logic [7:0]  t;
    logic [23:0] conv_rgb;
    logic [23:0] rgb_next;

    assign p_prod = {8'd0, s2_v} * {8'd0, s2_si};
    assign q_prod = {8'd0, s2_v} * {8'd0, 8'd255 - s2_sf};
    assign t_prod = {8'd0, s2_v} * {8'd0, 8'd255 - s2_sfn};
    assign p = p_prod[15:8];
    assign q = q_prod[15:8];
    assign t = t_prod[15:8];

    // sector to channel mapping; unreachable 6/7 fold into sector 5
    always_comb begin
        conv_rgb = {s2_v, p, q};
        case (s2_sector)
            3'd0:    conv_rgb = {s2_v, t, p};
            3'd1:    conv_rgb = {q, s2_v, p};
            3'd2:    conv_rgb = {p, s2_v, t};
            3'd3:    conv_rgb = {p, q, s2_v};
            3'd4:    conv_rgb = {t, p, s2_v};
            default: conv_rgb = {s2_v, p, q};
        endcase
`ifdef HSV_TO_RGB_GRAY_EXACT_EN
        if (s2_gray) begin
            conv_rgb = {s2_v, s2_v, s2_v};
        end
`endif
    end

    assign rgb_next = s2_conv ? conv_rgb : s2_raw;

    // output stage: rgb only loads on valid so it holds between pixels
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_out <= 1'b0;
            sb_out    <= '0;
            rgb_out   <= '0;
        end else begin
            valid_out <= s2_valid;
            sb_out    <= s2_sb;
            if (s2_valid) begin
                rgb_out <= rgb_next;
            end
        end
    end

endmodule

// File: tb/tb_hsv_to_rgb.sv
// tb_hsv_to_rgb: vector table, hand sequences and randomized stream
// checked against a cycle-history reference model.
module tb_hsv_to_rgb;

    localparam int NH = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in;
    logic [2:0]  sb_in;
    logic        convert_en;
    logic [23:0] hsv_in;
    logic        valid_out;
    logic [2:0]  sb_out;
    logic [23:0] rgb_out;

    hsv_to_rgb #(.SB_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .sb_in      (sb_in),
        .convert_en (convert_en),
        .hsv_in     (hsv_in),
        .valid_out  (valid_out),
        .sb_out     (sb_out),
        .rgb_out    (rgb_out)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // history of what was applied at each rising edge
    logic        hr [NH];
    logic        hv [NH];
    logic [2:0]  hs [NH];
    logic        hc [NH];
    logic [23:0] hh [NH];
    int          e = 0;

    logic        ev;
    logic [2:0]  esb;
    logic [23:0] ergb;
    logic [23:0] last_rgb = 24'd0;

    // reference conversion straight from the HSV rules
    function automatic logic [23:0] model(input logic [23:0] hsv,
                                          input logic conv);
        int h, s, v, h6, sec, f, sf, sfn, pp, qq, tt, r, g, b;
        if (!conv) return hsv;
        h = int'(hsv[23:16]);
        s = int'(hsv[15:8]);
        v = int'(hsv[7:0]);
        h6 = h * 6;
        sec = h6 / 256;
        f = h6 % 256;
        if (sec > 5) sec = 5;
`ifdef HSV_TO_RGB_GRAY_EXACT_EN
        if (s == 0) return {hsv[7:0], hsv[7:0], hsv[7:0]};
`endif
        sf  = (s * f) / 256;
        sfn = (s * (255 - f)) / 256;
        pp  = (v * (255 - s)) / 256;
        qq  = (v * (255 - sf)) / 256;
        tt  = (v * (255 - sfn)) / 256;
        case (sec)
            0: begin r = v;  g = tt; b = pp; end
            1: begin r = qq; g = v;  b = pp; end
            2: begin r = pp; g = v;  b = tt; end
            3: begin r = pp; g = qq; b = v;  end
            4: begin r = tt; g = pp; b = v;  end
            default: begin r = v; g = pp; b = qq; end
        endcase
        return {r[7:0], g[7:0], b[7:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %0h, required %0h",
                     name, e, act, exp);
        end
    endtask

    // one clock: apply inputs, update model at the edge, compare after
    task automatic cyc(input logic r, input logic v, input logic [2:0] s,
                       input logic c, input logic [23:0] h);
        rst = r; valid_in = v; sb_in = s; convert_en = c; hsv_in = h;
        @(posedge clk);
        hr[e] = r; hv[e] = v; hs[e] = s; hc[e] = c; hh[e] = h;
        if (!r) begin
            ev = 1'b0; esb = 3'd0; last_rgb = 24'd0;
        end else if (e < 2 || !hr[e-1] || !hr[e-2]) begin
            ev = 1'b0; esb = 3'd0;
        end else begin
            ev = hv[e-2];
            esb = hs[e-2];
            if (ev) last_rgb = model(hh[e-2], hc[e-2]);
        end
        ergb = last_rgb;
        @(negedge clk);
        check("valid_out", {31'd0, valid_out}, {31'd0, ev});
        check("sb_out", {29'd0, sb_out}, {29'd0, esb});
        check("rgb_out", {8'd0, rgb_out}, {8'd0, ergb});
        e++;
    endtask

    typedef struct {
        logic [23:0] hsv;
        logic        conv;
        logic [23:0] rgb;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{24'h00FFFF, 1'b1, 24'hFF0000};
        tbl[1] = '{24'h55FFFF, 1'b1, 24'h01FF00};
`ifdef HSV_TO_RGB_GRAY_EXACT_EN
        tbl[2] = '{24'h6400C8, 1'b1, 24'hC8C8C8};
`else
        tbl[2] = '{24'h6400C8, 1'b1, 24'hC7C8C7};
`endif
        tbl[3] = '{24'h123456, 1'b0, 24'h123456};
        tbl[4] = '{24'hFFFFFF, 1'b1, 24'hFF0005};
        tbl[5] = '{24'hAAFFFF, 1'b1, 24'h0003FF};
        tbl[6] = '{24'h80FF00, 1'b1, 24'h000000};

        // reset state
        cyc(1'b0, 1'b1, 3'd7, 1'b1, 24'hABCDEF);
        cyc(1'b0, 1'b0, 3'd0, 1'b0, 24'd0);
        check("reset_valid", {31'd0, valid_out}, 32'd0);
        check("reset_rgb", {8'd0, rgb_out}, 32'd0);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 24'd0);
        cyc(1'b1, 1'b0, 3'd0, 1'b0, 24'd0);

        // isolated vectors: result visible 3 edges after the sample
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b1, 3'd0, tbl[i].conv, tbl[i].hsv);
            cyc(1'b1, 1'b0, 3'd0, 1'b0, 24'd0);
            cyc(1'b1, 1'b0, 3'd0, 1'b0, 24'd0);
            check($sformatf("vec%0d_valid", i), {31'd0, valid_out}, 32'd1);
            check($sformatf("vec%0d_rgb", i), {8'd0, rgb_out},
                  {8'd0, tbl[i].rgb});
        end

        // single valid pulse with vsync sideband, passthrough mode
        begin
            int hits;
            hits = 0;
            cyc(1'b1, 1'b1, 3'b010, 1'b0, 24'h123456);
            for (int k = 0; k < 6; k++) begin
                cyc(1'b1, 1'b0, 3'b000, 1'b1, 24'hFFFFFF);
                if (valid_out) begin
                    hits++;
                    check("pulse_pos", k, 1);
                    check("pulse_sb", {29'd0, sb_out}, 32'h2);
                end
            end
            check("pulse_count", hits, 1);
            check("pulse_hold", {8'd0, rgb_out}, 32'h123456);
        end

        // mode flip mid-stream: in-flight pixels keep their mode
        for (int k = 0; k < 6; k++)
            cyc(1'b1, 1'b1, 3'd1, k[0], 24'h55FFFF);

        // continuous stream with a one-cycle reset in the middle
        for (int k = 0; k < 8; k++)
            cyc(1'b1, 1'b1, 3'(k), 1'b1, 24'($urandom));
        cyc(1'b0, 1'b1, 3'd5, 1'b1, 24'h00FFFF);
        check("midrst_valid", {31'd0, valid_out}, 32'd0);
        check("midrst_rgb", {8'd0, rgb_out}, 32'd0);
        cyc(1'b1, 1'b1, 3'd4, 1'b1, 24'h00FFFF);
        check("after_rst1", {31'd0, valid_out}, 32'd0);
        cyc(1'b1, 1'b1, 3'd3, 1'b1, 24'h55FFFF);
        check("after_rst2", {31'd0, valid_out}, 32'd0);
        cyc(1'b1, 1'b1, 3'd2, 1'b1, 24'hAAFFFF);
        check("first_out_valid", {31'd0, valid_out}, 32'd1);
        check("first_out_sb", {29'd0, sb_out}, 32'd4);
        check("first_out_rgb", {8'd0, rgb_out}, 32'hFF0000);

        // randomized traffic with occasional resets and corner hues
        for (int k = 0; k < 1500; k++) begin
            logic [23:0] h;
            h = 24'($urandom);
            if ($urandom_range(0, 5) == 0)
                h[23:16] = ($urandom_range(0, 1) == 0) ? 8'd255 : 8'd0;
            if ($urandom_range(0, 7) == 0)
                h[15:8] = 8'd0;
            cyc(($urandom_range(0, 49) != 0),
                ($urandom_range(0, 3) != 0),
                3'($urandom),
                ($urandom_range(0, 7) != 0),
                h);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hsv_to_rgb.md
HSV_TO_RGB -- requirements
Module: hsv_to_rgb

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter SB_W, default 3, SHALL set the sideband width (bit0 hsync, bit1 vsync, bit2 blank).
REQ-003 Port clk, input, 1: system clock, all state on its rising edge.
REQ-004 Port rst, input, 1: synchronous active-low reset.
REQ-005 Port valid_in, input, 1: hsv_in qualifier for this cycle.
REQ-006 Port sb_in, input, SB_W: video sideband aligned with hsv_in.
REQ-007 Port convert_en, input, 1: 1 selects conversion, 0 selects raw passthrough.
REQ-008 Port hsv_in, input, 24: H[23:16], S[15:8], V[7:0], each unsigned 0..255.
REQ-009 Port valid_out, output, 1: valid_in delayed by the pipeline latency.
REQ-010 Port sb_out, output, SB_W: sb_in delayed by the pipeline latency.
REQ-011 Port rgb_out, output, 24: R[23:16], G[15:8], B[7:0].

Function
REQ-012 Pipeline SHALL be fixed 3 stages; the input sampled at edge N SHALL appear on outputs after edge N+2 (3-cycle latency), with no stall and no backpressure.
REQ-013 valid, sb and convert_en SHALL travel in lockstep with data; every cycle SHALL advance the pipeline whether or not valid_in is set.
REQ-014 Stage 1 SHALL compute h6 = H*6 (11 bits), sector = h6[10:8], f = h6[7:0], and register S, V and the gray flag (S==0).
REQ-015 Stage 2 SHALL compute sf = (S*f)>>8, sfn = (S*(255-f))>>8 and si = 255-S, each 8 bits and truncating.
REQ-016 Stage 3 SHALL compute p = (V*si)>>8, q = (V*(255-sf))>>8 and t = (V*(255-sfn))>>8, truncating to 8 bits.
REQ-017 Stage 3 SHALL map (R,G,B) by sector: 0 gives (V,t,p), 1 gives (q,V,p), 2 gives (p,V,t), 3 gives (p,q,V), 4 gives (t,p,V), 5 gives (V,p,q).
REQ-018 Sector values 6 and 7 are unreachable and SHALL be treated as sector 5.
REQ-019 For H=255 the block SHALL use sector 5 with f=250, and no wrap to sector 0.
REQ-020 When the carried convert_en is 0, rgb_out SHALL equal the delayed hsv_in bit-for-bit.
REQ-021 A convert_en change SHALL affect only pixels sampled after the change; in-flight pixels keep their sampled mode.
REQ-022 rgb_out SHALL hold its last value while valid_out=0; downstream qualifies by valid_out only.

Reset
REQ-023 When rst=0 at a clock edge, valid_out, sb_out and rgb_out SHALL be 0 after that edge, and all internal valid, sb and convert_en stages SHALL clear.
REQ-024 A reset asserted mid-stream SHALL discard in-flight pixels; after release, the first valid_out SHALL correspond to the first valid_in sampled with rst=1, 3 cycles later.
REQ-025 Internal arithmetic registers MAY be left unreset, but they SHALL never reach outputs while valid_out=0 after reset.

Configuration
REQ-026 Macro HSV_TO_RGB_GRAY_EXACT_EN defined: when the gray flag is set and conversion is on, rgb_out SHALL be (V,V,V) exactly.
REQ-027 Macro HSV_TO_RGB_GRAY_EXACT_EN undefined: the gray flag SHALL be absent and the REQ-014..017 formulas SHALL apply unchanged for S=0, giving (V*255)>>8 for non-V channels.

Verification
REQ-028 hsv=(0,255,255), convert_en=1 -> rgb (255,0,0) 3 cycles later with valid_out=1.
REQ-029 hsv=(85,255,255) -> sector 1, f=254 -> rgb (1,255,0).
REQ-030 hsv=(100,0,200): with macro -> (200,200,200); without macro -> sector 2, (199,200,199).
REQ-031 Single valid_in pulse with sb_in=3'b010 at cycle 10 -> valid_out=1 and sb_out=3'b010 only in cycle 13; convert_en=0 with hsv 0x123456 -> rgb_out 0x123456.
REQ-032 Continuous stream, rst=0 for 1 cycle at cycle 20 -> outputs 0 next edge; pixels sampled in cycles 18-20 never appear; the pixel sampled in cycle 21 appears in cycle 24.
